alarm_time_keeper: RTL and testbench

ALARM_TIME_KEEPER -- requirements
Module: alarm_time_keeper

---
 rtl/alarm_time_keeper.sv | 171 +++++++++++++++++
 tb/tb_alarm_time_keeper.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_time_keeper.sv
// Alarm-clock time keeper: BCD HH:MM time of day, keypad entry buffer with
// inactivity timeout, and validated loads into the time and alarm registers.
module alarm_time_keeper (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        one_second,
    input  logic [3:0]  key,
    input  logic        key_valid,
    input  logic        load_new_time,
    input  logic        load_new_alarm,
    output logic [15:0] current_time,
    output logic [15:0] alarm_time,
    output logic [15:0] key_buffer,
    output logic        key_entry_active,
    output logic        load_err
);

    typedef enum logic {
        IDLE      = 1'b0,
        KEY_ENTRY = 1'b1
    } state_t;

    localparam logic [5:0] SEC_LAST     = 6'd59;
    localparam logic [3:0] TIMEOUT_LAST = 4'd9;
    // Wrap value of the minute digits: [0] = minute units, [1] = minute tens.
    localparam logic [3:0] MIN_DIGIT_MAX [2] = '{4'd9, 4'd5};

    state_t      state_reg, state_next;
    logic [15:0] time_reg,  time_next;
    logic [15:0] alarm_reg, alarm_next;
    logic [15:0] kbuf_reg,  kbuf_next;
    logic [5:0]  sec_reg,   sec_next;
    logic [3:0]  tmo_reg,   tmo_next;
    logic        err_reg,   err_next;

    logic        key_accept;
    logic        any_load;
    logic        load_ok;
    logic        time_load;
    logic        alarm_load;
    logic        load_reject;
    logic        tick;
    logic        minute_wrap;
    logic [15:0] kbuf_shifted;
    logic [2:0]  min_carry;
    logic [7:0]  min_plus_one;
    logic [7:0]  hour_plus_one;
    logic [3:0]  h_tens;
    logic [3:0]  h_units;

    // Request decode. Loads check the buffer as it stands before any key this cycle.
    assign key_accept  = key_valid && (key <= 4'd9);
    assign any_load    = load_new_time || load_new_alarm;
    assign load_ok     = (kbuf_reg[15:8] <= 8'h23) && (kbuf_reg[7:4] <= 4'd5);
    assign time_load   = load_new_time && !load_new_alarm && load_ok;
    assign alarm_load  = load_new_alarm && !load_new_time && load_ok;
    assign load_reject = any_load && !(time_load || alarm_load);
    assign tick        = one_second && !time_load;
    assign minute_wrap = tick && (sec_reg == SEC_LAST);

    // Keypad shift: newest digit enters at [3:0], oldest drops off the top.
    assign kbuf_shifted[3:0] = key;
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_kbuf_shift
            assign kbuf_shifted[gi*4 +: 4] = kbuf_reg[(gi-1)*4 +: 4];
        end
    endgenerate

    // Minute digits form a ripple-carry BCD chain; carry out feeds the hours.
    assign min_carry[0] = 1'b1;
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_min_digit
            logic digit_wrap;
            assign digit_wrap = (time_reg[gi*4 +: 4] == MIN_DIGIT_MAX[gi]);
            assign min_plus_one[gi*4 +: 4] =
                !min_carry[gi] ? time_reg[gi*4 +: 4] :
                digit_wrap     ? 4'd0 : time_reg[gi*4 +: 4] + 4'd1;
            assign min_carry[gi+1] = min_carry[gi] && digit_wrap;
        end
    endgenerate

    assign h_tens  = time_reg[15:12];
    assign h_units = time_reg[11:8];

    always_comb begin
        hour_plus_one = {h_tens, h_units};
        if (min_carry[2]) begin
            if (h_tens == 4'd2 && h_units == 4'd3) begin
                hour_plus_one = 8'h00;
            end else if (h_units == 4'd9) begin
                hour_plus_one = {h_tens + 4'd1, 4'd0};
            end else begin
                hour_plus_one = {h_tens, h_units + 4'd1};
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        time_next  = time_reg;
        alarm_next = alarm_reg;
        kbuf_next  = kbuf_reg;
        sec_next   = sec_reg;
        tmo_next   = tmo_reg;
        err_next   = 1'b0;

        // A successful time load restarts the minute and swallows a coincident tick.
        if (time_load) begin
            sec_next = 6'd0;
        end else if (tick) begin
            if (minute_wrap) begin
                sec_next  = 6'd0;
                time_next = {hour_plus_one, min_plus_one};
            end else begin
                sec_next = sec_reg + 6'd1;
            end
        end

        if (any_load) begin
            kbuf_next  = 16'h0000;
            state_next = IDLE;
            tmo_next   = 4'd0;
            err_next   = load_reject;
            if (time_load) begin
                time_next = kbuf_reg;
            end
            if (alarm_load) begin
                alarm_next = kbuf_reg;
            end
        end else if (key_accept) begin
            kbuf_next  = kbuf_shifted;
            state_next = KEY_ENTRY;
            tmo_next   = 4'd0;
        end else if (state_reg == KEY_ENTRY && one_second) begin
            if (tmo_reg == TIMEOUT_LAST) begin
                kbuf_next  = 16'h0000;
                state_next = IDLE;
                tmo_next   = 4'd0;
            end else begin
                tmo_next = tmo_reg + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            time_reg  <= 16'h0000;
            alarm_reg <= 16'h0000;
            kbuf_reg  <= 16'h0000;
            sec_reg   <= 6'd0;
            tmo_reg   <= 4'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            time_reg  <= time_next;
            alarm_reg <= alarm_next;
            kbuf_reg  <= kbuf_next;
            sec_reg   <= sec_next;
            tmo_reg   <= tmo_next;
            err_reg   <= err_next;
        end
    end

    assign current_time     = time_reg;
    assign alarm_time       = alarm_reg;
    assign key_buffer       = kbuf_reg;
    assign key_entry_active = (state_reg == KEY_ENTRY);
    assign load_err         = err_reg;

endmodule

// File: tb/tb_alarm_time_keeper.sv
// Bench for alarm_time_keeper: a decimal time-of-day/keypad model checked on
// every falling edge, plus directed sequences with literal expectations.
module tb_alarm_time_keeper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        one_second = 1'b0;
    logic [3:0]  key = 4'd0;
    logic        key_valid = 1'b0;
    logic        load_new_time = 1'b0;
    logic        load_new_alarm = 1'b0;
    logic [15:0] current_time;
    logic [15:0] alarm_time;
    logic [15:0] key_buffer;
    logic        key_entry_active;
    logic        load_err;

    int checks = 0;
    int errors = 0;

    alarm_time_keeper dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .one_second       (one_second),
        .key              (key),
        .key_valid        (key_valid),
        .load_new_time    (load_new_time),
        .load_new_alarm   (load_new_alarm),
        .current_time     (current_time),
        .alarm_time       (alarm_time),
        .key_buffer       (key_buffer),
        .key_entry_active (key_entry_active),
        .load_err         (load_err)
    );

    always #5 clk = ~clk;

    // Model: time as decimal hours/minutes, buffer as a list of decimal digits.
    int          m_hh = 0;
    int          m_mm = 0;
    int          m_sec = 0;
    int          m_tmo = 0;
    int          m_dig [4] = '{0, 0, 0, 0};
    bit          m_entry = 1'b0;
    bit          m_err = 1'b0;
    logic [15:0] m_alarm = 16'h0000;

    function automatic logic [15:0] to_bcd(int hh, int mm);
        return 16'((hh / 10) * 4096 + (hh % 10) * 256 + (mm / 10) * 16 + (mm % 10));
    endfunction

    function automatic logic [15:0] m_buf();
        return 16'(m_dig[3] * 4096 + m_dig[2] * 256 + m_dig[1] * 16 + m_dig[0]);
    endfunction

    task automatic model_clear_buf();
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
    endtask

    task automatic model_reset();
        m_hh = 0; m_mm = 0; m_sec = 0; m_tmo = 0;
        model_clear_buf();
        m_entry = 1'b0; m_err = 1'b0; m_alarm = 16'h0000;
    endtask

    task automatic model_step();
        int bh;
        int bm;
        int day_min;
        bit ok;
        bit tick;
        bh   = m_dig[3] * 10 + m_dig[2];
        bm   = m_dig[1] * 10 + m_dig[0];
        ok   = (bh <= 23) && (m_dig[1] <= 5);
        tick = one_second;
        m_err = 1'b0;
        if (load_new_time || load_new_alarm) begin
            if ((load_new_time && load_new_alarm) || !ok) begin
                m_err = 1'b1;
            end else if (load_new_time) begin
                m_hh = bh; m_mm = bm; m_sec = 0; tick = 1'b0;
            end else begin
                m_alarm = m_buf();
            end
            model_clear_buf();
            m_entry = 1'b0; m_tmo = 0;
        end else if (key_valid && key <= 4'd9) begin
            for (int i = 3; i > 0; i--) m_dig[i] = m_dig[i-1];
            m_dig[0] = int'(key);
            m_entry = 1'b1; m_tmo = 0;
        end else if (m_entry && one_second) begin
            m_tmo++;
            if (m_tmo == 10) begin
                model_clear_buf();
                m_entry = 1'b0; m_tmo = 0;
            end
        end
        if (tick) begin
            m_sec++;
            if (m_sec == 60) begin
                m_sec = 0;
                day_min = (m_hh * 60 + m_mm + 1) % 1440;
                m_hh = day_min / 60;
                m_mm = day_min % 60;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_step();
    end

    task automatic cmp16(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        cmp16(name, {15'b0, act}, {15'b0, exp});
    endtask

    always @(negedge clk) begin
        logic bad_digit;
        bad_digit = (current_time[3:0] > 4'd9) || (current_time[7:4] > 4'd5) ||
                    (current_time[11:8] > 4'd9) || (current_time[15:12] > 4'd2);
        cmp16("model_current_time", current_time, to_bcd(m_hh, m_mm));
        cmp16("model_alarm_time", alarm_time, m_alarm);
        cmp16("model_key_buffer", key_buffer, m_buf());
        chk1("model_key_entry_active", key_entry_active, m_entry);
        chk1("model_load_err", load_err, m_err);
        chk1("time_digits_bcd", bad_digit, 1'b0);
    end

    task automatic step(bit kv, logic [3:0] k, bit lt, bit la, bit os);
        @(negedge clk);
        key_valid = kv; key = k; load_new_time = lt; load_new_alarm = la; one_second = os;
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press(logic [3:0] k);
        step(1'b1, k, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic enter4(logic [15:0] v);
        press(v[15:12]); press(v[11:8]); press(v[7:4]); press(v[3:0]);
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
            idle();
        end
    endtask

    task automatic load_time(logic [15:0] v);
        enter4(v);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idle();
    endtask

    logic [15:0] wrap_start [4] = '{16'h2359, 16'h0959, 16'h1209, 16'h1959};
    logic [15:0] wrap_end   [4] = '{16'h0000, 16'h1000, 16'h1210, 16'h2000};

    initial begin
        repeat (3) @(negedge clk);
        cmp16("reset_time", current_time, 16'h0000);
        cmp16("reset_alarm", alarm_time, 16'h0000);
        cmp16("reset_kbuf", key_buffer, 16'h0000);
        chk1("reset_active", key_entry_active, 1'b0);
        chk1("reset_err", load_err, 1'b0);
        rst_n = 1'b1;

        // Basic entry, load and one-minute advance
        enter4(16'h1234);
        idle();
        cmp16("entry_kbuf", key_buffer, 16'h1234);
        chk1("entry_active", key_entry_active, 1'b1);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idle();
        cmp16("load_1234", current_time, 16'h1234);
        cmp16("load_clears_kbuf", key_buffer, 16'h0000);
        chk1("load_idle", key_entry_active, 1'b0);
        ticks(59);
        cmp16("59_ticks", current_time, 16'h1234);
        ticks(1);
        cmp16("60_ticks", current_time, 16'h1235);

        // BCD carry boundaries
        for (int i = 0; i < 4; i++) begin
            load_time(wrap_start[i]);
            cmp16("wrap_load", current_time, wrap_start[i]);
            ticks(60);
            cmp16("wrap_result", current_time, wrap_end[i]);
        end

        // Alarm loads: invalid hours, then valid
        enter4(16'h2500);
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        idle();
        chk1("bad_alarm_err", load_err, 1'b1);
        cmp16("bad_alarm_unchanged", alarm_time, 16'h0000);
        idle();
        chk1("err_one_cycle", load_err, 1'b0);
        enter4(16'h0730);
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        idle();
        cmp16("alarm_0730", alarm_time, 16'h0730);
        cmp16("alarm_keeps_time", current_time, 16'h2000);
        chk1("good_alarm_no_err", load_err, 1'b0);
        load_time(16'h1260);
        chk1("bad_minutes_err", load_err, 1'b1);
        cmp16("bad_minutes_time", current_time, 16'h2000);

        // Entry timeout and ignored keys
        press(4'd5);
        ticks(9);
        cmp16("tmo_9_kbuf", key_buffer, 16'h0005);
        chk1("tmo_9_active", key_entry_active, 1'b1);
        ticks(1);
        cmp16("tmo_10_kbuf", key_buffer, 16'h0000);
        chk1("tmo_10_active", key_entry_active, 1'b0);
        step(1'b1, 4'd11, 1'b0, 1'b0, 1'b0);
        idle();
        chk1("key11_idle", key_entry_active, 1'b0);
        press(4'd3);
        ticks(9);
        step(1'b1, 4'd12, 1'b0, 1'b0, 1'b0);
        idle();
        cmp16("key12_kbuf", key_buffer, 16'h0003);
        ticks(1);
        chk1("key12_no_restart", key_entry_active, 1'b0);

        // Conflicting loads, then time load with coincident tick
        load_time(16'h1200);
        enter4(16'h1200);
        step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        idle();
        chk1("both_loads_err", load_err, 1'b1);
        cmp16("both_loads_time", current_time, 16'h1200);
        cmp16("both_loads_alarm", alarm_time, 16'h0730);
        cmp16("both_loads_kbuf", key_buffer, 16'h0000);
        enter4(16'h0815);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        idle();
        cmp16("load_with_tick", current_time, 16'h0815);
        ticks(59);
        cmp16("dropped_tick_59", current_time, 16'h0815);
        ticks(1);
        cmp16("dropped_tick_60", current_time, 16'h0816);

        // Key coincident with load is discarded
        enter4(16'h0645);
        step(1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
        idle();
        cmp16("key_with_load_time", current_time, 16'h0645);
        cmp16("key_with_load_kbuf", key_buffer, 16'h0000);

        // Ticks keep running through alarm loads and rejected loads
        ticks(59);
        enter4(16'h0700);
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        idle();
        cmp16("alarm_tick_alarm", alarm_time, 16'h0700);
        cmp16("alarm_tick_time", current_time, 16'h0646);
        ticks(59);
        enter4(16'h9999);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        idle();
        chk1("bad_load_tick_err", load_err, 1'b1);
        cmp16("bad_load_tick_time", current_time, 16'h0647);

        // Load of an empty buffer from IDLE
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        idle();
        cmp16("idle_zero_alarm", alarm_time, 16'h0000);
        chk1("idle_zero_no_err", load_err, 1'b0);

        // Asynchronous reset mid-entry and mid-minute
        press(4'd1); press(4'd2);
        ticks(5);
        cmp16("pre_reset_kbuf", key_buffer, 16'h0012);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        cmp16("async_rst_time", current_time, 16'h0000);
        cmp16("async_rst_alarm", alarm_time, 16'h0000);
        cmp16("async_rst_kbuf", key_buffer, 16'h0000);
        chk1("async_rst_active", key_entry_active, 1'b0);
        chk1("async_rst_err", load_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        press(4'd4);
        idle();
        cmp16("post_rst_kbuf", key_buffer, 16'h0004);
        chk1("post_rst_active", key_entry_active, 1'b1);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        ticks(60);
        cmp16("post_rst_minute", current_time, 16'h0001);

        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
